interrupt_controller: RTL
=========================

# interrupt_controller

Memory-mapped interrupt controller between the peripherals and the processor's interrupt line. It latches raise requests from up to eight peripheral sources, acknowledges each peripheral on capture, and applies a per-source mask and a global enable. It forwards the highest-priority pending source to the processor over a single raise/ack handshake. It sits on the shared 8-bit data/address bus alongside RAM and the bus-interface peripherals.

## Interface
- BASE_ADDR, 8'hE0: base of the 4-byte register window (BASE..BASE+3); must be 4-aligned.
- NUM_SRC, 8: number of peripheral interrupt sources, 1..8; source 0 has the highest priority.

- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- BUS_DATA  inout  8  shared data bus; driven only during a read data cycle, otherwise high-Z.
- BUS_ADDR  in  8  shared address bus.
- BUS_WE  in  1  processor write strobe.
- SRC_RAISE  in  NUM_SRC  level raise request per peripheral; held by the peripheral until SRC_ACK.
- SRC_ACK  out  NUM_SRC  one-cycle capture acknowledge per peripheral.
- CPU_IRQ  out  1  raise to the processor interrupt line.
- CPU_ACK  in  1  processor acknowledge of CPU_IRQ.

## Operation
- Registers:
  - BASE+0 PENDING: read returns pending bits; write is W1C.
  - BASE+1 MASK: R/W; 1 = enabled; reset 0x00.
  - BASE+2 VECTOR: read-only; returns {1'b1, 4'b0, idx[2:0]} for the active source, or 0x00 when none is active.
  - BASE+3 CTRL: bit0 = global enable, bit1 = IRQ-in-progress (read-only); other bits read 0; reset 0x00.
- Capture: when SRC_RAISE[i]=1 and PENDING[i]=0, set PENDING[i] and pulse SRC_ACK[i] for exactly one cycle. Capture is independent of MASK; masked sources still latch.
- Eligible = PENDING & MASK & {NUM_SRC{CTRL[0]}}. The active source is the lowest-index eligible bit.
- FSM:
  - IDLE: go to RAISE when eligible is non-zero; latch the active index.
  - RAISE: CPU_IRQ=1. On CPU_ACK=1, go to SERVICE and drop CPU_IRQ on the same edge.
  - SERVICE: CPU_IRQ=0, CTRL[1]=1. Return to IDLE when the latched source's eligible bit goes to 0 (cleared, masked or globally disabled).
- The latched index is frozen from RAISE entry until IDLE. A higher-priority arrival during RAISE or SERVICE waits for the next IDLE→RAISE.
- If the latched source's eligible bit drops while in RAISE, return to IDLE without waiting for CPU_ACK.
- Bits of PENDING and MASK at or above NUM_SRC read 0 and ignore writes.

## Timing
- Reset values: PENDING=0, MASK=0, CTRL=0, state=IDLE, CPU_IRQ=0, SRC_ACK=0, BUS_DATA=Z.
- Asserting RESET mid-operation returns every output to its reset value immediately; the controller does not wait for the clock.
- SRC_RAISE high at edge N: PENDING set and SRC_ACK high after edge N, SRC_ACK low after N+1. A raise that stays high after the ack does not re-capture until PENDING[i] has been cleared.
- Pending eligible at edge N in IDLE: CPU_IRQ high after edge N+1. Latency from raise to CPU_IRQ is 2 cycles.
- Bus writes take effect at the edge where BUS_WE=1 and the address matches.
- Bus reads: address matches with BUS_WE=0 in cycle N → data is registered and driven during cycle N+1 only, then released to high-Z. There is no drive when BUS_WE=1.
- Simultaneous W1C of bit i and a new capture of source i in the same cycle: set wins. PENDING[i] stays 1 and SRC_ACK[i] pulses.
- Simultaneous capture of several sources: all latch and all SRC_ACK bits pulse in the same cycle.
- CPU_ACK outside RAISE is ignored.

## Test plan
- Reset: hold RESET=0 with SRC_RAISE=0xFF → CPU_IRQ=0, SRC_ACK=0, BUS_DATA=Z. Release reset → PENDING reads 0xFF, MASK reads 0x00, CPU_IRQ stays 0.
- Basic flow: MASK=0x08, CTRL=0x01, raise SRC 3 at edge N → SRC_ACK[3] is a single pulse after N, CPU_IRQ rises after N+1. VECTOR reads 0x83. CPU_ACK → CPU_IRQ=0, CTRL reads 0x03. W1C 0x08 → IDLE, CTRL reads 0x01.
- Priority: MASK=0xFF, raise sources 5 and 2 in the same cycle → both acks pulse, VECTOR=0x82. After clearing bit 2, a new RAISE cycle starts with VECTOR=0x85.
- Masking: pending 0x10 with MASK=0x00 → no CPU_IRQ. Write MASK=0x10 → CPU_IRQ 1 cycle later. Then clear CTRL[0] while in RAISE → CPU_IRQ drops and state returns to IDLE without CPU_ACK.
- Set-wins race: W1C of bit 1 in the same cycle that SRC_RAISE[1] re-asserts → PENDING[1] stays 1 and SRC_ACK[1] pulses.
- Reset mid-SERVICE: assert RESET between clock edges → CPU_IRQ, PENDING and CTRL read 0. Bus reads of BASE+0..3 return data only in the cycle after the address and are high-Z otherwise.

Source files
------------

// File: rtl/interrupt_controller.sv
// Latches up to eight peripheral raises, masks and prioritises them, and runs one raise/ack handshake to the CPU.
// Latency: raise to cpu_irq 2 cycles; register read data is driven one cycle after the address.
// Backpressure: a source holds its level raise until src_ack; the CPU holds off service by delaying cpu_ack.
module interrupt_controller #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_SRC   = 8
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [7:0]         bus_data,
    input  logic [7:0]         bus_addr,
    input  logic               bus_we,
    input  logic [NUM_SRC-1:0] src_raise,
    output logic [NUM_SRC-1:0] src_ack,
    output logic               cpu_irq,
    input  logic               cpu_ack
);

    typedef enum logic [1:0] {IDLE, RAISE, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] kept;
    logic [NUM_SRC-1:0] cap;
    logic               gen_en;
    logic [2:0]         act_idx;
    logic [2:0]         low_idx;
    logic [7:0]         elig;
    logic [7:0]         reg_dat;
    logic [7:0]         rd_dat;
    logic               rd_vld;
    logic               hit;

    assign hit  = (bus_addr[7:2] == BASE_ADDR[7:2]);
    assign w1c  = (hit && bus_we && bus_addr[1:0] == 2'd0) ? bus_data[NUM_SRC-1:0] : '0;
    // A raise captures against the post-clear value, so a same-cycle W1C loses to the new capture.
    assign kept = pending & ~w1c;
    assign cap  = src_raise & ~kept;
    assign elig = gen_en ? 8'(pending & mask) : 8'h00;

    always_comb begin
        low_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        reg_dat = 8'h00;
        case (bus_addr[1:0])
            2'd0:    reg_dat = 8'(pending);
            2'd1:    reg_dat = 8'(mask);
            2'd2:    reg_dat = (state != IDLE) ? {5'b10000, act_idx} : 8'h00;
            default: reg_dat = {6'b000000, state == SERVICE, gen_en};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            mask    <= '0;
            gen_en  <= 1'b0;
            src_ack <= '0;
            rd_vld  <= 1'b0;
            rd_dat  <= 8'h00;
        end else begin
            pending <= kept | cap;
            src_ack <= cap;
            rd_vld  <= hit && !bus_we;
            if (hit && !bus_we) rd_dat <= reg_dat;
            if (hit && bus_we && bus_addr[1:0] == 2'd1) mask   <= bus_data[NUM_SRC-1:0];
            if (hit && bus_we && bus_addr[1:0] == 2'd3) gen_en <= bus_data[0];
        end
    end

    // act_idx is frozen outside IDLE; newer, higher-priority sources wait for the next pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            act_idx <= 3'd0;
            cpu_irq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig != 8'h00) begin
                        state   <= RAISE;
                        act_idx <= low_idx;
                        cpu_irq <= 1'b1;
                    end
                end
                RAISE: begin
                    if (!elig[act_idx]) begin
                        state   <= IDLE;
                        cpu_irq <= 1'b0;
                    end else if (cpu_ack) begin
                        state   <= SERVICE;
                        cpu_irq <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (!elig[act_idx]) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cpu_irq <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data = (rd_vld && !bus_we) ? rd_dat : 8'hzz;

endmodule
